// File: rtl/tic_tac_toe_pkg.sv
// Shared definitions for the tic-tac-toe match controller and its timer.
package tic_tac_toe_pkg;

  // Controller state encoding, also exported on ctrl_state for display
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_GAME_END  = 3'd3,
    ST_MATCH_END = 3'd4
  } ctrl_state_t;

  // Button vector bit positions {L,R,U,D,C}
  localparam int BTN_L = 4;
  localparam int BTN_R = 3;
  localparam int BTN_U = 2;
  localparam int BTN_D = 1;
  localparam int BTN_C = 0;
  localparam int BTN_W = 5;

  localparam int SCORE_W = 4;
  localparam int TIMER_W = 6;

endpackage

// File: rtl/tic_tac_toe_match_ctrl_if.sv
// Connection between the match controller and the tic_tac_toe game core.
interface tic_tac_toe_match_ctrl_if;
  import tic_tac_toe_pkg::*;

  logic [BTN_W-1:0] core_btn;
  logic             core_restart;
  logic             core_p1won;
  logic             core_p2won;
  logic             core_moved;
  logic             core_full;

  // Controller side
  modport master (
    output core_btn, core_restart,
    input  core_p1won, core_p2won, core_moved, core_full
  );

  // Game core side
  modport slave (
    input  core_btn, core_restart,
    output core_p1won, core_p2won, core_moved, core_full
  );

endinterface

// File: rtl/tic_tac_toe_tick_timer.sv
// Loadable down-counter advanced by tick; expire flags the tick that
// lands on a count of 1 (the last allowed tick).
module tic_tac_toe_tick_timer
  import tic_tac_toe_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic         freeze,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         expire
);

  // Independent of load/freeze so callers can derive those from expire
  assign expire = tick && (count == W'(1));

  // Load has priority; otherwise count down on tick unless frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !freeze && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tic_tac_toe_match_ctrl.sv
// Match-level controller: routes the active player's buttons to the game
// core, runs the per-move timer, sequences games and keeps the score.
module tic_tac_toe_match_ctrl
  import tic_tac_toe_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int TURN_TICKS = 10,
  parameter int HOLD_TICKS = 4
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic [BTN_W-1:0]     a_btn,
  input  logic [BTN_W-1:0]     b_btn,
  tic_tac_toe_match_ctrl_if.master core,
  output logic                 turn,
  output logic                 first_b,
  output logic [SCORE_W-1:0]   a_score,
  output logic [SCORE_W-1:0]   b_score,
  output logic [TIMER_W-1:0]   time_left,
  output logic                 match_over,
  output logic                 winner_b,
  output logic [2:0]           ctrl_state
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

  ctrl_state_t        state, next_state;
  logic [1:0]         lock_cnt;
  logic               restart_q;
  logic [BTN_W-1:0]   routed;
  logic               btn_open;
  logic               c_fwd;
  logic               in_play, in_game_end, start_ok;
  logic               outcome, a_win, b_win;
  logic               turn_expire, hold_expire, hold_done;
  logic [TIMER_W-1:0] hold_left;
  logic               target_hit;
  logic               turn_load, turn_freeze;

  assign in_play     = (state == ST_PLAY);
  assign in_game_end = (state == ST_GAME_END);
  assign start_ok    = start && ((state == ST_IDLE) || (state == ST_MATCH_END));

  // Only the side on move reaches the core; the other side is dropped
  assign routed   = turn ? b_btn : a_btn;
  assign btn_open = in_play && (lock_cnt == 2'd0);
  assign c_fwd    = btn_open && routed[BTN_C];

  assign core.core_btn     = btn_open ? routed : '0;
  assign core.core_restart = restart_q;
  assign ctrl_state        = state;

  assign target_hit = (a_score == TARGET) || (b_score == TARGET);
  assign hold_done  = in_game_end && hold_expire && (hold_left != '0);

  // A move reloads the timer only when no outcome claims the same cycle
  assign turn_load   = (state == ST_CLEAR) || (in_play && core.core_moved && !outcome);
  assign turn_freeze = !in_play || outcome;

  tic_tac_toe_tick_timer #(.W(TIMER_W)) u_turn_timer (
    .clk      (Clk),
    .rst_n    (reset),
    .tick     (tick),
    .load     (turn_load),
    .freeze   (turn_freeze),
    .load_val (TIMER_W'(TURN_TICKS)),
    .count    (time_left),
    .expire   (turn_expire)
  );

  tic_tac_toe_tick_timer #(.W(TIMER_W)) u_hold_timer (
    .clk      (Clk),
    .rst_n    (reset),
    .tick     (tick),
    .load     (outcome),
    .freeze   (!in_game_end),
    .load_val (TIMER_W'(HOLD_TICKS)),
    .count    (hold_left),
    .expire   (hold_expire)
  );

  // Game outcome resolution: win by first mover, then second mover, then timeout, then draw
  always_comb begin
    outcome = 1'b0;
    a_win   = 1'b0;
    b_win   = 1'b0;
    if (in_play) begin
      if (core.core_p1won) begin
        outcome = 1'b1;
        b_win   = first_b;
        a_win   = !first_b;
      end else if (core.core_p2won) begin
        outcome = 1'b1;
        a_win   = first_b;
        b_win   = !first_b;
      end else if (turn_expire) begin
        outcome = 1'b1;
        a_win   = turn;
        b_win   = !turn;
      end else if (core.core_full) begin
        outcome = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (start) next_state = ST_CLEAR;
      ST_CLEAR:     next_state = ST_PLAY;
      ST_PLAY:      if (outcome) next_state = ST_GAME_END;
      ST_GAME_END:  if (hold_done) next_state = target_hit ? ST_MATCH_END : ST_CLEAR;
      ST_MATCH_END: if (start) next_state = ST_CLEAR;
      default:      next_state = ST_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      restart_q  <= 1'b0;
      match_over <= 1'b0;
    end else begin
      state      <= next_state;
      restart_q  <= (next_state == ST_CLEAR);
      match_over <= (next_state == ST_MATCH_END);
    end
  end

  // Turn ownership, first mover, and C-strobe lockout
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      turn     <= 1'b0;
      first_b  <= 1'b0;
      lock_cnt <= 2'd0;
    end else begin
      if (start_ok) begin
        first_b <= 1'b0;
      end else if (hold_done && !target_hit) begin
        first_b <= !first_b;
      end

      if (state == ST_CLEAR) begin
        turn <= first_b;
      end else if (in_play && core.core_moved && !outcome) begin
        turn <= !turn;
      end

      if (state == ST_CLEAR) begin
        lock_cnt <= 2'd0;
      end else if (c_fwd) begin
        lock_cnt <= 2'd2;
      end else if (lock_cnt != 2'd0) begin
        lock_cnt <= lock_cnt - 1'b1;
      end
    end
  end

  // Match score and winner
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      a_score  <= '0;
      b_score  <= '0;
      winner_b <= 1'b0;
    end else begin
      if (start_ok) begin
        a_score  <= '0;
        b_score  <= '0;
        winner_b <= 1'b0;
      end else begin
        if (a_win) a_score <= sat_inc(a_score);
        if (b_win) b_score <= sat_inc(b_score);
        if (hold_done && target_hit) winner_b <= (b_score == TARGET);
      end
    end
  end

endmodule

// File: tb/tb_tic_tac_toe_match_ctrl.sv
// Bench for tic_tac_toe_match_ctrl: directed stimulus pushes expected values
// into a scoreboard, a negedge monitor pops and compares them.
module tb_tic_tac_toe_match_ctrl;
  import tic_tac_toe_pkg::*;

  localparam int WT = 2;
  localparam int TT = 3;
  localparam int HT = 2;

  localparam int S_BTN = 0, S_RST = 1, S_TURN = 2, S_FIRST = 3, S_A = 4;
  localparam int S_B = 5, S_TL = 6, S_MO = 7, S_WB = 8, S_ST = 9;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic start = 1'b0;
  logic [4:0] a_btn = '0;
  logic [4:0] b_btn = '0;
  logic turn, first_b, match_over, winner_b;
  logic [3:0] a_score, b_score;
  logic [5:0] time_left;
  logic [2:0] ctrl_state;

  tic_tac_toe_match_ctrl_if core_bus();

  tic_tac_toe_match_ctrl #(
    .WIN_TARGET(WT), .TURN_TICKS(TT), .HOLD_TICKS(HT)
  ) dut (
    .Clk(Clk), .reset(reset), .tick(tick), .start(start),
    .a_btn(a_btn), .b_btn(b_btn), .core(core_bus),
    .turn(turn), .first_b(first_b), .a_score(a_score), .b_score(b_score),
    .time_left(time_left), .match_over(match_over), .winner_b(winner_b),
    .ctrl_state(ctrl_state)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_BTN:   return 32'(core_bus.core_btn);
      S_RST:   return 32'(core_bus.core_restart);
      S_TURN:  return 32'(turn);
      S_FIRST: return 32'(first_b);
      S_A:     return 32'(a_score);
      S_B:     return 32'(b_score);
      S_TL:    return 32'(time_left);
      S_MO:    return 32'(match_over);
      S_WB:    return 32'(winner_b);
      default: return 32'(ctrl_state);
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (probe(cur.sel) !== cur.exp) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %0h expected %0h", cur.name, cyc, probe(cur.sel), cur.exp);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_v(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic expect_idle_zero(input string tag);
    expect_v(S_BTN, 0, {tag, "_btn"});   expect_v(S_RST, 0, {tag, "_restart"});
    expect_v(S_TURN, 0, {tag, "_turn"}); expect_v(S_FIRST, 0, {tag, "_first_b"});
    expect_v(S_A, 0, {tag, "_a_score"}); expect_v(S_B, 0, {tag, "_b_score"});
    expect_v(S_TL, 0, {tag, "_time_left"}); expect_v(S_MO, 0, {tag, "_match_over"});
    expect_v(S_WB, 0, {tag, "_winner_b"}); expect_v(S_ST, 0, {tag, "_state"});
  endtask

  task automatic start_match(input string tag);
    start = 1'b1; step(); start = 1'b0;
    expect_v(S_ST, 1, {tag, "_clear_state"}); expect_v(S_RST, 1, {tag, "_restart_hi"});
    expect_v(S_A, 0, {tag, "_a_clr"}); expect_v(S_B, 0, {tag, "_b_clr"});
    expect_v(S_FIRST, 0, {tag, "_first_b_clr"}); expect_v(S_MO, 0, {tag, "_mo_clr"});
    step();
    expect_v(S_ST, 2, {tag, "_play_state"}); expect_v(S_RST, 0, {tag, "_restart_lo"});
    expect_v(S_TURN, 0, {tag, "_turn0"}); expect_v(S_TL, TT, {tag, "_tl_load"});
    checks++;
    if (ctrl_state !== 3'd2) begin
      errors++;
      $display("FAIL %s_play_direct: got %0d expected 2", tag, ctrl_state);
    end
    checks++;
    if (time_left !== 6'(TT)) begin
      errors++;
      $display("FAIL %s_tl_direct: got %0d expected %0d", tag, time_left, TT);
    end
  endtask

  task automatic hold();
    for (int i = 0; i < HT; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (i < HT - 1) step();
    end
  endtask

  task automatic pulse_tick(input int exp_tl, input string n);
    tick = 1'b1; step(); tick = 1'b0;
    expect_v(S_TL, exp_tl, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout required completion");
    $fatal(1);
  end

  initial begin
    core_bus.core_p1won = 1'b0;
    core_bus.core_p2won = 1'b0;
    core_bus.core_moved = 1'b0;
    core_bus.core_full  = 1'b0;

    // Reset state
    step(); step();
    expect_idle_zero("por");
    step();
    reset = 1'b1;
    step();

    // ---------------- Match 1 ----------------
    start_match("m1");
    b_btn = 5'b00001; expect_v(S_BTN, 0, "idle_side_drop"); step(); b_btn = '0;
    a_btn = 5'b00001; expect_v(S_BTN, 5'b00001, "a_c_forward"); step();
    expect_v(S_BTN, 0, "lockout_1"); step();
    expect_v(S_BTN, 0, "lockout_2"); step();
    a_btn = 5'b10000; expect_v(S_BTN, 5'b10000, "after_lockout"); step(); a_btn = '0;
    core_bus.core_moved = 1'b1; step(); core_bus.core_moved = 1'b0;
    expect_v(S_TURN, 1, "move_toggle_b"); expect_v(S_TL, TT, "move_reload");
    b_btn = 5'b00100; a_btn = 5'b01000;
    expect_v(S_BTN, 5'b00100, "route_b"); step(); b_btn = '0; a_btn = '0;
    start = 1'b1; step(); start = 1'b0;
    expect_v(S_ST, 2, "start_ignored_play"); expect_v(S_RST, 0, "start_ignored_rst");
    core_bus.core_moved = 1'b1; step(); core_bus.core_moved = 1'b0;
    expect_v(S_TURN, 0, "move_toggle_a");
    pulse_tick(2, "tick_dec_2");
    step();
    pulse_tick(1, "tick_dec_1");
    tick = 1'b1; step(); tick = 1'b0;
    expect_v(S_ST, 3, "timeout_game_end"); expect_v(S_B, 1, "timeout_b_score");
    expect_v(S_A, 0, "timeout_a_score"); expect_v(S_TL, 1, "timeout_tl_frozen");
    checks++;
    if (b_score !== 4'd1) begin
      errors++;
      $display("FAIL timeout_b_direct: got %0d expected 1", b_score);
    end
    a_btn = 5'b00001; expect_v(S_BTN, 0, "game_end_btn_blocked"); step(); a_btn = '0;
    hold();
    expect_v(S_ST, 1, "g1_to_clear"); expect_v(S_FIRST, 1, "g1_first_b_toggle");
    expect_v(S_RST, 1, "g2_restart");
    step();
    expect_v(S_TURN, 1, "g2_turn_b"); expect_v(S_TL, TT, "g2_tl_load");
    pulse_tick(2, "g2_tick_2");
    pulse_tick(1, "g2_tick_1");
    tick = 1'b1; core_bus.core_p1won = 1'b1; core_bus.core_moved = 1'b1;
    step();
    tick = 1'b0; core_bus.core_p1won = 1'b0; core_bus.core_moved = 1'b0;
    expect_v(S_ST, 3, "win_beats_timeout_state"); expect_v(S_B, 2, "win_beats_timeout_b");
    expect_v(S_A, 0, "win_beats_timeout_a"); expect_v(S_TURN, 1, "moved_ignored_on_outcome");
    expect_v(S_TL, 1, "g2_tl_frozen");
    hold();
    expect_v(S_ST, 4, "m1_match_end"); expect_v(S_MO, 1, "m1_match_over");
    expect_v(S_WB, 1, "m1_winner_b"); expect_v(S_B, 2, "m1_b_held");
    a_btn = 5'b00001; expect_v(S_BTN, 0, "match_end_btn_blocked"); step(); a_btn = '0;

    // ---------------- Match 2 ----------------
    start_match("m2");
    core_bus.core_full = 1'b1; step(); core_bus.core_full = 1'b0;
    expect_v(S_ST, 3, "draw_state"); expect_v(S_A, 0, "draw_a"); expect_v(S_B, 0, "draw_b");
    hold();
    expect_v(S_ST, 1, "draw_to_clear"); expect_v(S_FIRST, 1, "draw_first_alt");
    step();
    expect_v(S_TURN, 1, "m2g2_turn_b");
    core_bus.core_p2won = 1'b1; step(); core_bus.core_p2won = 1'b0;
    expect_v(S_A, 1, "p2won_a_scores"); expect_v(S_B, 0, "p2won_b_same");
    hold();
    expect_v(S_FIRST, 0, "m2g3_first_a");
    step();
    expect_v(S_ST, 2, "m2g3_play"); expect_v(S_TURN, 0, "m2g3_turn_a");
    expect_v(S_A, 1, "m2g3_a_before_reset");
    step();
    reset = 1'b0;
    expect_idle_zero("mid_reset");
    step();
    reset = 1'b1;
    step();
    expect_v(S_ST, 0, "post_reset_idle"); expect_v(S_RST, 0, "post_reset_no_restart");
    checks++;
    if (ctrl_state !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_idle_direct: got %0d expected 0", ctrl_state);
    end
    step();
    expect_v(S_RST, 0, "post_reset_no_restart_2");

    // ---------------- Match 3 ----------------
    start_match("m3");
    core_bus.core_p1won = 1'b1; step(); core_bus.core_p1won = 1'b0;
    expect_v(S_A, 1, "m3_p1won_a"); expect_v(S_B, 0, "m3_p1won_b");
    hold();
    expect_v(S_FIRST, 1, "m3_first_b");
    step();
    expect_v(S_TURN, 1, "m3g2_turn_b");
    core_bus.core_p2won = 1'b1; step(); core_bus.core_p2won = 1'b0;
    expect_v(S_A, 2, "m3_p2won_a"); expect_v(S_B, 0, "m3_p2won_b");
    hold();
    expect_v(S_ST, 4, "m3_match_end"); expect_v(S_MO, 1, "m3_match_over");
    expect_v(S_WB, 0, "m3_winner_a");
    checks++;
    if (match_over !== 1'b1) begin
      errors++;
      $display("FAIL m3_match_over_direct: got %0b expected 1", match_over);
    end
    start_match("m4");

    repeat (3) step();
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got unchecked expected monitor comparison", cur.name);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
